// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for the shared logic-unit arbiter.
// Optional rsp_zero member exists only with LOGIC_ARB_ZFLAG_EN.
interface logic_unit_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [2*NREQ-1:0]  req_op;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;
`ifdef LOGIC_ARB_ZFLAG_EN
    logic               rsp_zero;
`endif

    // master: requesters and result consumer; slave: the arbiter
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
`ifdef LOGIC_ARB_ZFLAG_EN
        , input rsp_zero
`endif
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
`ifdef LOGIC_ARB_ZFLAG_EN
        , output rsp_zero
`endif
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise AND/OR/XOR/NOR unit, with a registered result.
// Optional zero flag on the result: define LOGIC_ARB_ZFLAG_EN.
//
// state   | meaning
// EMPTY   | no result held, rsp_valid=0
// FULL    | result held in output register, rsp_valid=1
module logic_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 2
) (
    input logic                  clk_i,
    input logic                  reset_n_i,
    logic_unit_arbiter_if.slave  bus
);
    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [DW-1:0]   data_q, data_d;
`ifdef LOGIC_ARB_ZFLAG_EN
    logic            zero_q, zero_d;
`endif

    logic            can_issue;
    logic            found;
    logic [IDW-1:0]  idx;
    logic [IDW-1:0]  gnt_idx;
    logic [NREQ-1:0] grant;
    logic [1:0]      op_sel;
    logic [DW-1:0]   a_sel, b_sel, result;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        data_d    = data_q;
`ifdef LOGIC_ARB_ZFLAG_EN
        zero_d    = zero_q;
`endif
        found     = 1'b0;
        idx       = '0;
        gnt_idx   = '0;
        grant     = '0;
        op_sel    = 2'b00;
        a_sel     = '0;
        b_sel     = '0;
        result    = '0;
        // grants are masked while reset is held so nothing is accepted into a clearing register
        can_issue = reset_n_i && ((state_q == S_EMPTY) || bus.rsp_ready);

        if (can_issue) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = IDW'((int'(rr_q) + k) % NREQ);
                if (!found && bus.req_valid[idx]) begin
                    found   = 1'b1;
                    gnt_idx = idx;
                end
            end
        end

        if (found) begin
            grant[gnt_idx] = 1'b1;
            op_sel = bus.req_op[2*gnt_idx +: 2];
            a_sel  = bus.req_a[DW*gnt_idx +: DW];
            b_sel  = bus.req_b[DW*gnt_idx +: DW];
            case (op_sel)
                2'b00:   result = a_sel & b_sel;
                2'b01:   result = a_sel | b_sel;
                2'b10:   result = a_sel ^ b_sel;
                default: result = ~(a_sel | b_sel);
            endcase
            data_d  = result;
            id_d    = gnt_idx;
`ifdef LOGIC_ARB_ZFLAG_EN
            zero_d  = (result == '0);
`endif
            state_d = S_FULL;
            rr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if ((state_q == S_FULL) && bus.rsp_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_EMPTY;
            rr_q    <= '0;
            id_q    <= '0;
            data_q  <= '0;
`ifdef LOGIC_ARB_ZFLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            data_q  <= data_d;
`ifdef LOGIC_ARB_ZFLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state_q == S_FULL);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
`ifdef LOGIC_ARB_ZFLAG_EN
    assign bus.rsp_zero  = zero_q;
`endif
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, ops, round-robin order, backpressure, zero flag.
module tb_logic_unit_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic_unit_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

    logic_unit_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[2*i +: 2] = op;
        bus.req_a[DW*i +: DW] = a;
        bus.req_b[DW*i +: DW] = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // reset state, and no grant while reset is held
        #2;
        bus.req_valid = 4'hF;
        #1;
        check("reset_req_ready", 64'(bus.req_ready), 64'h0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("reset_rsp_data",  64'(bus.rsp_data),  64'h0);
        check("reset_rsp_id",    64'(bus.rsp_id),    64'h0);
        bus.req_valid = '0;
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        // single OR op from requester 1
        set_req(1, 2'b01, 32'h0000_F0F0, 32'h0F0F_0000);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        #1;
        check("single_ready", 64'(bus.req_ready), 64'h2);
        next_cycle();
        bus.req_valid = '0;
        check("single_valid", 64'(bus.rsp_valid), 64'h1);
        check("single_id",    64'(bus.rsp_id),    64'h1);
        check("single_data",  64'(bus.rsp_data),  64'h0F0F_F0F0);
        next_cycle();
        check("drain_empty",  64'(bus.rsp_valid), 64'h0);

        // AND (req2), XOR (req3), NOR (req0), back to back; rr pointer is 2 here
        set_req(2, 2'b00, 32'hFFFF_0000, 32'hFF00_FF00);
        set_req(3, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00);
        set_req(0, 2'b11, 32'hFFFF_0000, 32'hFF00_FF00);
        bus.req_valid = 4'b0100;
        #1;
        check("and_ready", 64'(bus.req_ready), 64'h4);
        next_cycle();
        check("and_data", 64'(bus.rsp_data), 64'hFF00_0000);
        check("and_id",   64'(bus.rsp_id),   64'h2);
        bus.req_valid = 4'b1000;
        #1;
        check("xor_ready", 64'(bus.req_ready), 64'h8);
        next_cycle();
        check("xor_data", 64'(bus.rsp_data), 64'h00FF_FF00);
        check("xor_id",   64'(bus.rsp_id),   64'h3);
        bus.req_valid = 4'b0001;
        #1;
        check("nor_ready", 64'(bus.req_ready), 64'h1);
        next_cycle();
        check("nor_data", 64'(bus.rsp_data), 64'h0000_00FF);
        check("nor_id",   64'(bus.rsp_id),   64'h0);
        // rr pointer is now 1; a lone req 3 wins and wraps the pointer to 0
        bus.req_valid = 4'b1000;
        #1;
        check("wrap_ready", 64'(bus.req_ready), 64'h8);
        next_cycle();

        // round-robin: all valid, each req i does OR of i with 0x100
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 32'(i), 32'h100);
        bus.req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            exp_gnt = 4'b0001 << (c % 4);
            #1;
            check("rr_ready", 64'(bus.req_ready), 64'(exp_gnt));
            next_cycle();
            check("rr_valid", 64'(bus.rsp_valid), 64'h1);
            check("rr_id",    64'(bus.rsp_id),    64'(c % 4));
            check("rr_data",  64'(bus.rsp_data),  64'(32'h100 | 32'(c % 4)));
        end

        // backpressure: result of req 3 (0x103) held, req 2 waiting
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_ready", 64'(bus.req_ready), 64'h0);
            check("bp_valid", 64'(bus.rsp_valid), 64'h1);
            check("bp_id",    64'(bus.rsp_id),    64'h3);
            check("bp_data",  64'(bus.rsp_data),  64'h103);
            next_cycle();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.req_ready), 64'h4);
        next_cycle();
        check("bp_release_id",   64'(bus.rsp_id),   64'h2);
        check("bp_release_data", 64'(bus.rsp_data), 64'h102);

        // zero-flag operands: AND gives 0, OR gives all ones
        set_req(0, 2'b00, 32'hAAAA_AAAA, 32'h5555_5555);
        bus.req_valid = 4'b0001;
        next_cycle();
        check("zand_data", 64'(bus.rsp_data), 64'h0);
`ifdef LOGIC_ARB_ZFLAG_EN
        check("zand_zero", 64'(bus.rsp_zero), 64'h1);
`endif
        set_req(0, 2'b01, 32'hAAAA_AAAA, 32'h5555_5555);
        next_cycle();
        check("zor_data", 64'(bus.rsp_data), 64'hFFFF_FFFF);
`ifdef LOGIC_ARB_ZFLAG_EN
        check("zor_zero", 64'(bus.rsp_zero), 64'h0);
`endif

        // reset mid-FULL clears immediately, pointer returns to 0
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        check("pre_reset_valid", 64'(bus.rsp_valid), 64'h1);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.rsp_valid), 64'h0);
        check("midrst_data",  64'(bus.rsp_data),  64'h0);
        check("midrst_ready", 64'(bus.req_ready), 64'h0);
        check("midrst_id",    64'(bus.rsp_id),    64'h0);
        next_cycle();
        reset_n = 1'b1;
        #1;
        check("postrst_ready", 64'(bus.req_ready), 64'h1);
        next_cycle();
        check("postrst_id", 64'(bus.rsp_id), 64'h0);
        bus.req_valid = '0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
